// File: rtl/frogg_hop_input.sv
// Button front-end for the frog controller: synchronise, debounce, one hop per press, FWFT hop FIFO.
// Define FROGG_HOP_REPEAT_EN to generate auto-repeat hops while a single button is held.
module frogg_hop_input #(
    parameter int c_DEBOUNCE_LIMIT = 250000,
    parameter int c_FIFO_DEPTH     = 4,
    parameter int c_REPEAT_DELAY   = 12500000,
    parameter int c_REPEAT_RATE    = 5000000
) (
    input  logic                            i_Clk,
    input  logic                            i_Rst_L,
    input  logic                            i_Paddle_Up,
    input  logic                            i_Paddle_Dn,
    input  logic                            i_Paddle_lt,
    input  logic                            i_Paddle_rt,
    input  logic                            i_Hop_Ready,
    output logic                            o_Hop_Valid,
    output logic [1:0]                      o_Hop_Dir,
    output logic [3:0]                      o_Btn_Level,
    output logic                            o_Hop_Drop,
    output logic [$clog2(c_FIFO_DEPTH):0]   o_Fifo_Count
);
    localparam int DB_W  = $clog2(c_DEBOUNCE_LIMIT);
    localparam int PTR_W = $clog2(c_FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(c_DEBOUNCE_LIMIT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(c_FIFO_DEPTH);

    logic [3:0]       raw;
    logic [3:0]       sync1_q, sync1_d, sync2_q, sync2_d;
    logic [3:0]       level_q, level_d, level_prev_q, level_prev_d;
    logic [DB_W-1:0]  db_cnt_q [4];
    logic [DB_W-1:0]  db_cnt_d [4];
    logic [3:0]       edge_press, press;
    logic [3:0]       pending_q, pending_d;
    logic             sel_valid;
    logic [1:0]       sel_dir;
    logic             full, push, pop;
    logic             drop_q, drop_d;
    logic [1:0]       mem_q [c_FIFO_DEPTH];
    logic [1:0]       mem_d [c_FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    assign raw = {i_Paddle_rt, i_Paddle_lt, i_Paddle_Dn, i_Paddle_Up};

    // NOTE: every always_comb output gets a default before any branch, so no latch can be inferred.
    always_comb begin
        sync1_d      = raw;
        sync2_d      = sync1_q;
        level_d      = level_q;
        level_prev_d = level_q;
        for (int i = 0; i < 4; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) level_d[i] = ~level_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
            end
        end
        edge_press = level_q & ~level_prev_q;
    end

`ifdef FROGG_HOP_REPEAT_EN
    localparam int REP_MAX = (c_REPEAT_DELAY > c_REPEAT_RATE) ? c_REPEAT_DELAY : c_REPEAT_RATE;
    localparam int REP_W   = $clog2(REP_MAX + 1);
    localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(c_REPEAT_DELAY - 1);
    localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(c_REPEAT_RATE - 1);

    logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_rate_q, rep_rate_d;
    logic             rep_fire;

    // rep_rate_q selects the inter-repeat period once the first repeat has fired.
    always_comb begin
        rep_fire   = 1'b0;
        rep_cnt_d  = rep_cnt_q + REP_W'(1);
        rep_rate_d = rep_rate_q;
        if (!$onehot(level_q) || (edge_press != 4'b0000)) begin
            rep_cnt_d  = '0;
            rep_rate_d = 1'b0;
        end else if (rep_cnt_q == (rep_rate_q ? RATE_LAST : DELAY_LAST)) begin
            rep_fire   = 1'b1;
            rep_cnt_d  = '0;
            rep_rate_d = 1'b1;
        end
        press = edge_press | (rep_fire ? level_q : 4'b0000);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            rep_cnt_q  <= '0;
            rep_rate_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_rate_q <= rep_rate_d;
        end
    end
`else
    logic unused_repeat_cfg;
    assign unused_repeat_cfg = ^{c_REPEAT_DELAY, c_REPEAT_RATE};
    assign press = edge_press;
`endif

    // Fixed priority up > down > left > right; only the granted flag is cleared.
    always_comb begin
        sel_valid = |pending_q;
        if      (pending_q[0]) sel_dir = 2'd0;
        else if (pending_q[1]) sel_dir = 2'd1;
        else if (pending_q[2]) sel_dir = 2'd2;
        else                   sel_dir = 2'd3;

        pending_d = pending_q;
        if (sel_valid) pending_d[sel_dir] = 1'b0;
        pending_d = pending_d | press;

        full   = (count_q == FULL_CNT);
        pop    = (count_q != '0) && i_Hop_Ready;
        push   = sel_valid && (!full || pop);
        drop_d = sel_valid && full && !pop;

        mem_d = mem_q;
        if (push) mem_d[wr_ptr_q] = sel_dir;
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            level_q      <= '0;
            level_prev_q <= '0;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= '0;
            pending_q    <= '0;
            drop_q       <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            level_q      <= level_d;
            level_prev_q <= level_prev_d;
            for (int i = 0; i < 4; i++) db_cnt_q[i] <= db_cnt_d[i];
            pending_q    <= pending_d;
            drop_q       <= drop_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries are only visible through count_q, which is reset.
    always_ff @(posedge i_Clk) begin
        mem_q <= mem_d;
    end

    assign o_Hop_Valid  = (count_q != '0);
    assign o_Hop_Dir    = o_Hop_Valid ? mem_q[rd_ptr_q] : 2'b00;
    assign o_Btn_Level  = level_q;
    assign o_Hop_Drop   = drop_q;
    assign o_Fifo_Count = count_q;

endmodule
